button_encoder: RTL and testbench
=================================

Name: button_encoder

Overview:
Input-side counterpart to the 7-segment display path. It conditions the raw board buttons (4 ALU operation buttons plus the mode button) through synchronisation and per-button debouncing. It then encodes each clean press into a single-cycle command for the control FSM: 2-bit op code plus valid strobe, and a mode strobe. It sits between the board pins and fsm_mealy, replacing direct use of raw button levels.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips (min 2).
CNT_W, $clog2(DEBOUNCE_CYCLES)+1, debounce counter width (derived, not overridden).

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous reset, active-high
ALUbotones_raw  input  4  raw asynchronous ALU buttons, bit i selects operation i
CambioModo_raw  input  1  raw asynchronous mode button
ALUbotones  output  4  debounced stable levels of the ALU buttons
op_valid  output  1  one-cycle strobe: a single clean ALU press was accepted
op_code  output  2  index of the accepted button, held until the next op_valid
multi_err  output  1  one-cycle strobe: press rejected because >1 button was stable-high
mode_pulse  output  1  one-cycle strobe on a clean mode-button press
modo  output  1  mode level, toggles on every mode_pulse

Behaviour:
- Reset (rst=1 at a clk edge): all synchroniser flops, stable levels, counters, op_code, modo set to 0. All strobes are 0. FSM goes to IDLE. Reset has priority over everything.
- Synchroniser: 2 flops per input (sync1, sync2), all 5 inputs.
- Debounce, per input, independent counters:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Rising edge of stable is detected against a registered copy of it. All strobes are registered. A strobe is high exactly the one cycle after the cycle in which stable rose.
- Latency: raw high before edge 1 gives sync2=1 after edge 2. stable rises at edge 2+DEBOUNCE_CYCLES. The strobe is high after edge 3+DEBOUNCE_CYCLES, for 1 cycle. Release has the same debounce latency and produces no strobe.
- Encoder FSM, states IDLE and HOLD:
  - IDLE, any ALU stable rising edge, exactly one ALU stable bit high: op_valid=1, op_code <= that index, go to HOLD.
  - IDLE, any ALU stable rising edge, more than one bit high (simultaneous edges included): multi_err=1, op_valid=0, op_code unchanged, go to HOLD.
  - HOLD: ignore all new ALU edges. Return to IDLE when all 4 ALU stable bits are 0. No strobe is emitted on return.
- Mode path is independent of the FSM. A mode stable rising edge gives mode_pulse=1 and toggles modo. It may coincide with op_valid or multi_err in the same cycle, and both are emitted.
- Reset mid-press: state clears. A button still held after reset release debounces as a fresh press and yields op_valid.
- op_code keeps its value across HOLD/IDLE. It changes only with op_valid.

Test Plan:
- DEBOUNCE_CYCLES=4: raise ALUbotones_raw=4'b0100 before edge 1 and hold it. Required: ALUbotones[2]=1 after edge 6; op_valid=1 and op_code=2 only in the cycle after edge 7; op_valid=0 after edge 8.
- Bounce: toggle raw bit 0 high for 3 cycles, low 1, high 2, low. Required: no op_valid and ALUbotones stays 0. Then hold bit 0 high for 10 cycles. Required: exactly one op_valid with op_code=0.
- Hold button 1 after it is accepted, then press button 3 while 1 is still held. Required: no second strobe. Release all, wait the debounce time, press 3. Required: op_valid with op_code=3.
- Raise raw buttons 0 and 3 on the same edge. Required: multi_err=1 for one cycle, op_valid=0, op_code unchanged from its prior value.
- Press mode 3 times, in the same cycle as an ALU press the first time. Required: mode_pulse ×3; modo goes 1,0,1; op_valid coincides with the first mode_pulse.
- Assert rst for 1 cycle while button 2 is held and stable in HOLD. Required: all outputs 0 the cycle after reset. op_valid with op_code=2 appears DEBOUNCE_CYCLES+3 edges after reset release.

Source files
------------

// File: rtl/button_encoder.sv
// button_encoder: synchronises and debounces the board buttons and turns clean presses into single-cycle commands
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   ALUbotones_raw  - raw asynchronous ALU operation buttons (bit i = operation i)
//   CambioModo_raw  - raw asynchronous mode button
//   ALUbotones      - debounced stable ALU button levels
//   op_valid        - one-cycle strobe, single clean ALU press accepted
//   op_code         - index of the accepted button, held until the next op_valid
//   multi_err       - one-cycle strobe, press rejected because several buttons were high
//   mode_pulse      - one-cycle strobe on a clean mode press
//   modo            - mode level, toggles on every mode_pulse
module button_encoder #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ALUbotones_raw,
    input  logic       CambioModo_raw,
    output logic [3:0] ALUbotones,
    output logic       op_valid,
    output logic [1:0] op_code,
    output logic       multi_err,
    output logic       mode_pulse,
    output logic       modo
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    // bit 4 carries the mode button, bits 3:0 the ALU buttons
    logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0] stable_q, stable_d, prev_q, prev_d, rise;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    state_t state_q, state_d;
    logic op_valid_q, op_valid_d, multi_err_q, multi_err_d;
    logic mode_pulse_q, mode_pulse_d, modo_q, modo_d;
    logic [1:0] op_code_q, op_code_d;
    logic accept, one_hot;

    always_comb begin
        sync1_d = {CambioModo_raw, ALUbotones_raw};
        sync2_d = sync1_q;
        stable_d = stable_q;
        prev_d = stable_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise = stable_q & ~prev_q;
    assign one_hot = $onehot(stable_q[3:0]);
    assign accept = (state_q == IDLE) && |rise[3:0];

    always_comb begin
        op_valid_d = accept && one_hot;
        multi_err_d = accept && !one_hot;
        // one-hot to index: bit 3 -> 3, bit 2 -> 2, bit 1 -> 1, bit 0 -> 0
        op_code_d = op_valid_d ? {stable_q[3] | stable_q[2], stable_q[3] | stable_q[1]} : op_code_q;
        state_d = accept ? HOLD : (state_q == HOLD && stable_q[3:0] == 4'b0) ? IDLE : state_q;
        mode_pulse_d = rise[4];
        modo_d = modo_q ^ rise[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            stable_q <= '0;
            prev_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            state_q <= IDLE;
            op_valid_q <= 1'b0;
            op_code_q <= '0;
            multi_err_q <= 1'b0;
            mode_pulse_q <= 1'b0;
            modo_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            stable_q <= stable_d;
            prev_q <= prev_d;
            cnt_q <= cnt_d;
            state_q <= state_d;
            op_valid_q <= op_valid_d;
            op_code_q <= op_code_d;
            multi_err_q <= multi_err_d;
            mode_pulse_q <= mode_pulse_d;
            modo_q <= modo_d;
        end
    end

    assign ALUbotones = stable_q[3:0];
    assign op_valid = op_valid_q;
    assign op_code = op_code_q;
    assign multi_err = multi_err_q;
    assign mode_pulse = mode_pulse_q;
    assign modo = modo_q;
endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder: directed checks of button_encoder with a strobe scoreboard
module tb_button_encoder;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] alu_raw = 4'b0;
    logic mode_raw = 1'b0;
    logic [3:0] ALUbotones;
    logic op_valid, multi_err, mode_pulse, modo;
    logic [1:0] op_code;

    button_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk),
        .rst(rst),
        .ALUbotones_raw(alu_raw),
        .CambioModo_raw(mode_raw),
        .ALUbotones(ALUbotones),
        .op_valid(op_valid),
        .op_code(op_code),
        .multi_err(multi_err),
        .mode_pulse(mode_pulse),
        .modo(modo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int cyc;
        logic v;
        logic [1:0] code;
        logic me;
        logic mp;
        logic md;
    } ev_t;

    ev_t q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // a press driven at the negedge of cycle c strobes at the negedge of cycle c+3+D
    task automatic push(input int at, input logic v, input logic [1:0] code, input logic me, input logic mp, input logic md);
        q.push_back('{at, v, code, me, mp, md});
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (op_valid | multi_err | mode_pulse) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 32'({op_valid, multi_err, mode_pulse}), 32'(0));
            end else begin
                e = q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                check("strobe_fields", 32'({op_valid, op_code, multi_err, mode_pulse, modo}),
                      32'({e.v, e.code, e.me, e.mp, e.md}));
            end
        end
    end

    initial begin
        int c;
        step(3);
        check("rst_levels", 32'(ALUbotones), 32'(0));
        check("rst_strobes", 32'({op_valid, multi_err, mode_pulse}), 32'(0));
        check("rst_code_modo", 32'({op_code, modo}), 32'(0));
        rst = 1'b0;
        step(1);
        alu_raw = 4'b0100;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        step(5);
        check("lat_level_pre", 32'(ALUbotones), 32'(0));
        step(1);
        check("lat_level", 32'(ALUbotones), 32'(4'b0100));
        step(1);
        check("lat_valid", 32'(op_valid), 32'(1));
        check("lat_code", 32'(op_code), 32'(2));
        step(1);
        check("lat_valid_off", 32'(op_valid), 32'(0));
        alu_raw = 4'b0;
        step(10);
        alu_raw = 4'b0001;
        step(3);
        alu_raw = 4'b0;
        step(1);
        alu_raw = 4'b0001;
        step(2);
        alu_raw = 4'b0;
        step(10);
        check("bounce_level", 32'(ALUbotones), 32'(0));
        alu_raw = 4'b0001;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(10);
        alu_raw = 4'b0;
        step(10);
        alu_raw = 4'b0010;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step(10);
        alu_raw = 4'b1010;
        step(10);
        check("hold_levels", 32'(ALUbotones), 32'(4'b1010));
        alu_raw = 4'b0;
        step(10);
        alu_raw = 4'b1000;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        step(10);
        alu_raw = 4'b0;
        step(10);
        alu_raw = 4'b0010;
        mode_raw = 1'b1;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1);
        step(10);
        check("modo_1", 32'(modo), 32'(1));
        alu_raw = 4'b0;
        mode_raw = 1'b0;
        step(10);
        mode_raw = 1'b1;
        c = cyc;
        push(c + 3 + D, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        step(10);
        check("modo_2", 32'(modo), 32'(0));
        mode_raw = 1'b0;
        step(10);
        mode_raw = 1'b1;
        c = cyc;
        push(c + 3 + D, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1);
        step(10);
        check("modo_3", 32'(modo), 32'(1));
        mode_raw = 1'b0;
        step(10);
        alu_raw = 4'b1001;
        c = cyc;
        push(c + 3 + D, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
        step(3 + D);
        check("multi_err_on", 32'({multi_err, op_valid}), 32'(2'b10));
        check("multi_code_kept", 32'(op_code), 32'(1));
        step(1);
        check("multi_err_off", 32'(multi_err), 32'(0));
        alu_raw = 4'b0;
        step(10);
        alu_raw = 4'b0100;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        step(10);
        rst = 1'b1;
        step(1);
        check("mid_rst_levels", 32'(ALUbotones), 32'(0));
        check("mid_rst_outs", 32'({op_valid, op_code, multi_err, mode_pulse, modo}), 32'(0));
        rst = 1'b0;
        c = cyc;
        push(c + 3 + D, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        step(2 + D);
        check("rerun_valid_pre", 32'(op_valid), 32'(0));
        step(1);
        check("rerun_valid", 32'({op_valid, op_code}), 32'({1'b1, 2'd2}));
        step(1);
        alu_raw = 4'b0;
        step(10);
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
